// File: rtl/fix_ari_acc.sv
// Fixed-point accumulator behind fix_ari_mul: sums len products, returns a saturated WIDTH-bit result.
// Optional macro FIX_ARI_ACC_ROUND_EN selects round-half-up instead of truncation on the output shift.
module fix_ari_acc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned ACC_W = 40
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [LEN_W-1:0]            len,
    input  logic                        in_valid,
    input  logic signed [2*WIDTH-2:0]   in_data,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [ACC_W-1:0]            out_full,
    output logic                        out_sat,
    output logic                        drop
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (WIDTH-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (WIDTH-1)));

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic [LEN_W-1:0]        count, count_nxt, count_inc;
    logic [LEN_W-1:0]        len_q, len_nxt;
    logic                    busy_nxt, out_valid_nxt, out_sat_nxt, drop_nxt;
    logic [WIDTH-1:0]        out_data_nxt;
    logic [ACC_W-1:0]        out_full_nxt;

    logic signed [ACC_W-1:0] sum_c, acc_rnd_c, r_c;
    logic [WIDTH-1:0]        res_data_c;
    logic                    res_sat_c;

    // Running sum including the current product, and its scaled/saturated result
    assign sum_c     = acc + ACC_W'(in_data);
    assign count_inc = count + LEN_W'(1);

`ifdef FIX_ARI_ACC_ROUND_EN
    assign acc_rnd_c = sum_c + ACC_W'(1 << (FRAC-1));
`else
    assign acc_rnd_c = sum_c;
`endif

    assign r_c = acc_rnd_c >>> FRAC;

    always_comb begin
        res_sat_c  = 1'b0;
        res_data_c = r_c[WIDTH-1:0];
        if (r_c > SAT_MAX) begin
            res_sat_c  = 1'b1;
            res_data_c = WIDTH'(SAT_MAX);
        end else if (r_c < SAT_MIN) begin
            res_sat_c  = 1'b1;
            res_data_c = WIDTH'(SAT_MIN);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        count_nxt     = count;
        len_nxt       = len_q;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_full_nxt  = out_full;
        out_sat_nxt   = out_sat;
        drop_nxt      = drop;

        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt   = '0;
                    count_nxt = '0;
                    len_nxt   = len;
                    drop_nxt  = 1'b0;
                    if (len == '0) begin
                        state_nxt     = DONE;
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = '0;
                        out_full_nxt  = '0;
                        out_sat_nxt   = 1'b0;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
                if (in_valid) drop_nxt = 1'b1;
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_nxt   = sum_c;
                    count_nxt = count_inc;
                    if (count_inc == len_q) begin
                        state_nxt     = DONE;
                        out_valid_nxt = 1'b1;
                        out_data_nxt  = res_data_c;
                        out_full_nxt  = sum_c;
                        out_sat_nxt   = res_sat_c;
                    end
                end
            end
            DONE: begin
                if (in_valid) drop_nxt = 1'b1;
                if (out_ready) begin
                    state_nxt     = IDLE;
                    out_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            len_q     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_full  <= '0;
            out_sat   <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            count     <= count_nxt;
            len_q     <= len_nxt;
            busy      <= busy_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_full  <= out_full_nxt;
            out_sat   <= out_sat_nxt;
            drop      <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_fix_ari_acc.sv
// Scoreboard bench for fix_ari_acc: expected results queued at stimulus time, checked on output handshake.
module tb_fix_ari_acc;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [7:0]         len;
    logic               in_valid;
    logic signed [30:0] in_data;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic signed [39:0] out_full;
    logic               out_sat;
    logic               drop;

    typedef struct {
        longint full;
        longint data;
        logic   sat;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    exp_t   stall_e;
    int     prods[$];
    int     checks   = 0;
    int     failures = 0;

    fix_ari_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_full  (out_full),
        .out_sat   (out_sat),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input longint sum);
        exp_t   e;
        longint r;
        e.full = sum;
`ifdef FIX_ARI_ACC_ROUND_EN
        r = (sum + 128) >>> 8;
`else
        r = sum >>> 8;
`endif
        if (r > 32767) begin
            e.data = 32767;  e.sat = 1'b1;
        end else if (r < -32768) begin
            e.data = -32768; e.sat = 1'b1;
        end else begin
            e.data = r;      e.sat = 1'b0;
        end
        return e;
    endfunction

    // Output monitor: pop one expectation per accepted result
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", longint'(out_data), mon_e.data);
                check("out_full", longint'(out_full), mon_e.full);
                check("out_sat",  longint'(out_sat),  longint'(mon_e.sat));
            end
        end
    end

    // Drives one run using the products in prods, with gap idle cycles between valids
    task automatic run(input int gap);
        longint sum = 0;
        int     n   = prods.size();
        foreach (prods[i]) sum += longint'(prods[i]);
        exp_q.push_back(model(sum));
        start = 1'b1;
        len   = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start", longint'(busy), 1);
        check("drop_clr", longint'(drop), 0);
        if (n == 0) check("len0_valid", longint'(out_valid), 1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 31'(prods[i]);
            if (i == n-1) check("lat_pre", longint'(out_valid), 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i == n-1) check("lat_post", longint'(out_valid), 1);
            else repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", longint'(busy), 0);
    endtask

    initial begin
        start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  longint'(busy),      0);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_data",  longint'(out_data),  0);
        check("rst_full",  longint'(out_full),  0);
        check("rst_sat",   longint'(out_sat),   0);
        check("rst_drop",  longint'(drop),      0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        prods = {65536, 65536, 65536, 65536};
        run(2); wait_idle();
        prods = {536870912, 536870912, 536870912};
        run(0); wait_idle();
        prods = {-10000000, -10000000};
        run(1); wait_idle();
        prods = {384};
        run(0); wait_idle();
        prods = {-384};
        run(0); wait_idle();
        prods.delete();
        for (int i = 0; i < 8; i++) prods.push_back(int'($urandom_range(2097152)) - 1048576);
        run(1); wait_idle();

        // Stall the result, check it holds, and poke in_valid while DONE
        out_ready = 1'b0;
        prods = {1000, 2000};
        stall_e = model(3000);
        run(0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_valid", longint'(out_valid), 1);
            check("hold_data",  longint'(out_data),  stall_e.data);
            check("hold_full",  longint'(out_full),  3000);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("drop_set", longint'(drop), 1);
        check("drop_hold_valid", longint'(out_valid), 1);
        out_ready = 1'b1;
        wait_idle();
        check("drop_sticky", longint'(drop), 1);

        prods.delete();
        run(0); wait_idle();

        // Abort mid-run with reset
        prods = {-10000000, -10000000};
        run(0); wait_idle();
        start = 1'b1; len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 31'(65536);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_busy",  longint'(busy),      0);
        check("abort_valid", longint'(out_valid), 0);
        check("abort_data",  longint'(out_data),  0);
        check("abort_full",  longint'(out_full),  0);
        check("abort_sat",   longint'(out_sat),   0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        prods = {256};
        run(0); wait_idle();

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fix_ari_acc.md
Name: fix_ari_acc

Overview:
Fixed-point accumulator stage that sits directly downstream of the fix_ari_mul fixed-point multiplier. It consumes the multiplier's full-precision signed product stream, which carries 2*FRAC fractional bits. It sums a programmed number of products into a wide accumulator. It then returns the sum as a saturated WIDTH-bit value with FRAC fractional bits through a valid/ready output, forming the accumulate half of a dot-product/MAC datapath.

Parameters:
WIDTH, 16, operand width of the upstream multiplier; product width is 2*WIDTH-1; result width is WIDTH.
FRAC, 8, fractional bits per operand; products carry 2*FRAC fractional bits.
LEN_W, 8, width of the length field; at most 2^LEN_W-1 products per run.
ACC_W, 40, accumulator width; must be >= 2*WIDTH-1+LEN_W, so the accumulator never wraps.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
len  in  LEN_W  number of products to accumulate; sampled when start is honoured.
in_valid  in  1  product valid; no backpressure, since the multiplier cannot stall.
in_data  in  2*WIDTH-1  signed product from fix_ari_mul data_out.
busy  out  1  high in ACCUM and DONE.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  WIDTH  signed saturated result with FRAC fractional bits.
out_full  out  ACC_W  raw accumulator with 2*FRAC fractional bits.
out_sat  out  1  out_data was clipped; valid with out_valid.
drop  out  1  sticky; set when in_valid arrives outside ACCUM; cleared only by start.

Behaviour:
- Reset, asynchronous: state=IDLE; acc=0; count=0; busy=0; out_valid=0; out_data=0; out_full=0; out_sat=0; drop=0.
- Reset asserted mid-run aborts the run immediately; no partial result is produced.
- State IDLE:
  - start=1 with len!=0: acc<=0, count<=0, latch len, clear drop, go to ACCUM.
  - start=1 with len==0: acc<=0, go to DONE; the result is 0 with out_sat=0.
  - in_valid=1 sets drop.
- State ACCUM:
  - Each cycle with in_valid=1: acc<=acc+sign_extend(in_data), count<=count+1.
  - The cycle that accepts product number len goes to DONE.
  - start is ignored in ACCUM.
- State DONE:
  - out_valid=1; out_data, out_full and out_sat are registered and hold stable until handshake.
  - On out_valid&&out_ready: go to IDLE and drop out_valid the next cycle.
  - in_valid=1 sets drop; start is ignored.
- Latency: out_valid rises on the clock edge after the final product is accepted.
- Back-to-back runs: start may be issued in the first IDLE cycle after the handshake.
- Arithmetic:
  - Product input is signed; the accumulator is signed ACC_W bits.
  - Result: r = acc >>> FRAC (arithmetic shift, truncation toward -inf).
  - If r > 2^(WIDTH-1)-1, then out_data = 2^(WIDTH-1)-1 and out_sat=1.
  - If r < -2^(WIDTH-1), then out_data = -2^(WIDTH-1) and out_sat=1.
  - Otherwise out_data = r[WIDTH-1:0] and out_sat=0.
  - out_full = acc, unsaturated.
- A count value beyond len is unreachable; the FSM leaves ACCUM on equality.

Optional Feature:
FIX_ARI_ACC_ROUND_EN:
- Defined: round half up before the shift, r = (acc + 2^(FRAC-1)) >>> FRAC. Saturation is applied after rounding.
- Undefined: plain truncation as above.
- out_full is unaffected in both cases.

Test Plan:
- Basic sum: len=4, four products of 65536 (1.0*1.0) with gaps between valids -> out_full=262144, out_data=1024 (4.0), out_sat=0; out_valid rises one cycle after the 4th product.
- Positive saturation: len=3, three products of 536870912 -> r=6291456, out_data=32767, out_sat=1.
- Negative saturation and sign: len=2, two products of -10000000 (-20000*500) -> out_full=-20000000, out_data=-32768, out_sat=1.
- Rounding, single product:
  - in_data=384 -> out_data=1 without macro, 2 with FIX_ARI_ACC_ROUND_EN.
  - in_data=-384 -> out_data=-2 without macro, -1 with it.
- Handshake/drop/len=0:
  - Hold out_ready=0 for 5 cycles -> outputs remain stable.
  - in_valid pulsed in DONE -> drop=1, and the next start clears it.
  - start with len=0 -> out_valid next cycle with out_data=0.
- Reset mid-run: deassert rst_n after 2 of 4 products -> all outputs 0 immediately; a fresh run of len=1 with product 256 gives out_data=1.
